// File: rtl/bytecode_decoder.sv
// rtl/bytecode_decoder.sv - JVM integer bytecode decoder executing on an internal operand stack.
module bytecode_decoder #(
   parameter int DATA_WIDTH  = 32,
   parameter int STACK_DEPTH = 8,
   parameter int PTR_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_for_decoder,
   input  logic [15:0]           data_for_decoder,
   output logic                  ready_from_decoder,
   output logic [DATA_WIDTH-1:0] top_of_stack,
   output logic [PTR_WIDTH-1:0]  stack_depth,
   output logic                  illegal_opcode,
   output logic                  stack_error,
   output logic [15:0]           retired_count
);

   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0] FULL = PTR_WIDTH'(STACK_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t                r_state;
   logic                  r_ready;
   logic [7:0]            r_opcode;
   logic [7:0]            r_operand;
   logic [DATA_WIDTH-1:0] r_stack [STACK_DEPTH];
   logic [PTR_WIDTH-1:0]  r_depth;
   logic                  r_illegal;
   logic                  r_error;
   logic [15:0]           r_retired;

   logic [PTR_WIDTH-1:0]  w_idx_b;
   logic [PTR_WIDTH-1:0]  w_idx_a;
   logic [DATA_WIDTH-1:0] w_b;
   logic [DATA_WIDTH-1:0] w_a;
   logic                  w_legal;
   logic [1:0]            w_req;
   logic                  w_grow;
   logic                  w_shrink;
   logic                  w_write;
   logic [DATA_WIDTH-1:0] w_result;
   logic                  w_underflow;
   logic                  w_overflow;
   logic [PTR_WIDTH-1:0]  w_new_depth;
   logic [PTR_WIDTH-1:0]  w_wr_idx;

   // b is the current top, a the entry beneath it; values are meaningless when underflowing
   assign w_idx_b = r_depth - PTR_WIDTH'(1);
   assign w_idx_a = r_depth - PTR_WIDTH'(2);
   assign w_b     = r_stack[w_idx_b[IDX_W-1:0]];
   assign w_a     = r_stack[w_idx_a[IDX_W-1:0]];

   always_comb begin
      w_legal  = 1'b1;
      w_req    = 2'd0;
      w_grow   = 1'b0;
      w_shrink = 1'b0;
      w_write  = 1'b0;
      w_result = '0;
      case (r_opcode)
         8'h00: ;
         8'h02: begin
            w_grow   = 1'b1;
            w_write  = 1'b1;
            w_result = '1;
         end
         8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08: begin
            w_grow   = 1'b1;
            w_write  = 1'b1;
            w_result = DATA_WIDTH'(r_opcode - 8'h03);
         end
         8'h10: begin
            w_grow   = 1'b1;
            w_write  = 1'b1;
            w_result = {{(DATA_WIDTH-8){r_operand[7]}}, r_operand};
         end
         8'h57: begin
            w_req    = 2'd1;
            w_shrink = 1'b1;
         end
         8'h59: begin
            w_req    = 2'd1;
            w_grow   = 1'b1;
            w_write  = 1'b1;
            w_result = w_b;
         end
         8'h60, 8'h64, 8'h68: begin
            w_req    = 2'd2;
            w_shrink = 1'b1;
            w_write  = 1'b1;
            if (r_opcode == 8'h60)
               w_result = w_a + w_b;
            else if (r_opcode == 8'h64)
               w_result = w_a - w_b;
            else
               w_result = w_a * w_b;
         end
         8'h74: begin
            w_req    = 2'd1;
            w_write  = 1'b1;
            w_result = '0 - w_b;
         end
         8'h91: begin
            w_req    = 2'd1;
            w_write  = 1'b1;
            w_result = {{(DATA_WIDTH-8){w_b[7]}}, w_b[7:0]};
         end
         default: w_legal = 1'b0;
      endcase
   end

   assign w_underflow = r_depth < PTR_WIDTH'(w_req);
   assign w_overflow  = w_grow && (r_depth == FULL);
   assign w_new_depth = r_depth + PTR_WIDTH'(w_grow) - PTR_WIDTH'(w_shrink);
   // every writing opcode leaves its result as the new top
   assign w_wr_idx    = w_new_depth - PTR_WIDTH'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b1;
         r_opcode  <= 8'h00;
         r_operand <= 8'h00;
         r_depth   <= '0;
         r_illegal <= 1'b0;
         r_error   <= 1'b0;
         r_retired <= 16'h0000;
         for (int i = 0; i < STACK_DEPTH; i++)
            r_stack[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_for_decoder) begin
                  r_opcode  <= data_for_decoder[15:8];
                  r_operand <= data_for_decoder[7:0];
                  r_ready   <= 1'b0;
                  r_state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!w_legal)
                  r_illegal <= 1'b1;
               else if (w_underflow || w_overflow)
                  r_error <= 1'b1;
               else begin
                  if (w_write)
                     r_stack[w_wr_idx[IDX_W-1:0]] <= w_result;
                  r_depth   <= w_new_depth;
                  r_retired <= r_retired + 16'd1;
               end
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready_from_decoder = r_ready;
   assign top_of_stack       = (r_depth == '0) ? '0 : w_b;
   assign stack_depth        = r_depth;
   assign illegal_opcode     = r_illegal;
   assign stack_error        = r_error;
   assign retired_count      = r_retired;

endmodule

// File: tb/tb_bytecode_decoder.sv
// tb/tb_bytecode_decoder.sv - randomized bench for bytecode_decoder against a queue-based stack model.
module tb_bytecode_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] data = 16'h0000;
   logic        ready;
   logic [31:0] top;
   logic [3:0]  depth;
   logic        ill;
   logic        err;
   logic [15:0] retired;

   int n_checks = 0;
   int n_fails  = 0;

   logic [31:0] m_stk[$];
   bit          m_ill;
   bit          m_err;
   logic [15:0] m_cnt;

   bytecode_decoder #(.DATA_WIDTH(32), .STACK_DEPTH(8), .PTR_WIDTH(4)) dut (
      .clk                (clk),
      .reset              (reset),
      .start_for_decoder  (start),
      .data_for_decoder   (data),
      .ready_from_decoder (ready),
      .top_of_stack       (top),
      .stack_depth        (depth),
      .illegal_opcode     (ill),
      .stack_error        (err),
      .retired_count      (retired)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_stk.delete();
      m_ill = 0;
      m_err = 0;
      m_cnt = 16'h0000;
   endfunction

   function automatic void model_exec(input logic [15:0] w);
      logic [7:0]  op = w[15:8];
      logic [31:0] a, b;
      int          sz = m_stk.size();
      case (op)
         8'h00: m_cnt++;
         8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h10: begin
            if (sz == 8) m_err = 1;
            else begin
               if (op == 8'h02)      m_stk.push_back(32'hFFFF_FFFF);
               else if (op == 8'h10) m_stk.push_back(32'(int'($signed(w[7:0]))));
               else                  m_stk.push_back(32'(int'(op) - 3));
               m_cnt++;
            end
         end
         8'h57: begin
            if (sz < 1) m_err = 1;
            else begin void'(m_stk.pop_back()); m_cnt++; end
         end
         8'h59: begin
            if (sz < 1 || sz == 8) m_err = 1;
            else begin m_stk.push_back(m_stk[$]); m_cnt++; end
         end
         8'h60, 8'h64, 8'h68: begin
            if (sz < 2) m_err = 1;
            else begin
               b = m_stk.pop_back();
               a = m_stk.pop_back();
               if (op == 8'h60)      m_stk.push_back(a + b);
               else if (op == 8'h64) m_stk.push_back(a - b);
               else                  m_stk.push_back(32'(int'(a) * int'(b)));
               m_cnt++;
            end
         end
         8'h74, 8'h91: begin
            if (sz < 1) m_err = 1;
            else begin
               b = m_stk.pop_back();
               if (op == 8'h74) m_stk.push_back(32'(-int'(b)));
               else             m_stk.push_back(32'(int'($signed(b[7:0]))));
               m_cnt++;
            end
         end
         default: m_ill = 1;
      endcase
   endfunction

   task automatic check_state(input string tag);
      check_eq({tag, "_depth"}, depth, m_stk.size());
      check_eq({tag, "_top"}, top, (m_stk.size() == 0) ? 32'h0 : m_stk[$]);
      check_eq({tag, "_ill"}, ill, m_ill);
      check_eq({tag, "_err"}, err, m_err);
      check_eq({tag, "_retired"}, retired, m_cnt);
   endtask

   task automatic do_reset();
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      #1;
      model_reset();
      check_eq("rst_ready", ready, 1);
      check_state("rst");
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic send_word(input logic [15:0] w, input bit full_check);
      int waited = 0;
      @(negedge clk);
      while (!ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (!ready) begin
         check_eq("ready_wait", ready, 1);
         return;
      end
      start = 1'b1;
      data  = w;
      @(posedge clk);
      #1;
      start = 1'b0;
      data  = $urandom;
      @(negedge clk);
      check_eq("ready_exec", ready, 0);
      @(negedge clk);
      check_eq("ready_done", ready, 0);
      @(negedge clk);
      check_eq("ready_back", ready, 1);
      model_exec(w);
      if (full_check) check_state("word");
   endtask

   logic [7:0] legal_ops [16] = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                  8'h10, 8'h57, 8'h59, 8'h60, 8'h64, 8'h68, 8'h74, 8'h91};

   initial begin
      model_reset();
      do_reset();

      send_word(16'h0300, 1);
      send_word(16'h0400, 1);
      check_eq("tp1_depth", depth, 2);
      check_eq("tp1_top", top, 1);
      check_eq("tp1_retired", retired, 2);

      do_reset();
      send_word(16'h10FB, 1);
      send_word(16'h1005, 1);
      send_word(16'h6000, 1);
      check_eq("tp2_top", top, 0);
      check_eq("tp2_depth", depth, 1);
      send_word(16'h7400, 1);
      send_word(16'h9100, 1);
      check_eq("tp2_top_i2b", top, 0);

      do_reset();
      send_word(16'h107F, 1);
      send_word(16'h5900, 1);
      send_word(16'h6800, 1);
      check_eq("tp3_top", top, 32'h0000_3F01);
      check_eq("tp3_depth", depth, 1);

      do_reset();
      for (int i = 0; i < 9; i++) send_word(16'h0500, 1);
      check_eq("tp4_err", err, 1);
      check_eq("tp4_depth", depth, 8);
      check_eq("tp4_retired", retired, 8);
      do_reset();
      send_word(16'h5700, 1);
      check_eq("tp4_uflow_err", err, 1);
      check_eq("tp4_uflow_depth", depth, 0);

      do_reset();
      send_word(16'h0700, 1);
      send_word(16'h6F00, 1);
      send_word(16'h5000, 1);
      check_eq("tp5_ill", ill, 1);
      check_eq("tp5_depth", depth, 1);
      check_eq("tp5_retired", retired, 1);

      // start held high: accepts land every third cycle
      do_reset();
      data  = 16'h0400;
      start = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         check_eq("held_ready", ready, (i % 3 == 0) ? 1 : 0);
      end
      start = 1'b0;
      for (int i = 0; i < 3; i++) model_exec(16'h0400);
      check_state("held");

      @(negedge clk);
      start = 1'b1;
      data  = 16'h0800;
      @(posedge clk);
      #1;
      start = 1'b0;
      reset = 1'b0;
      #1;
      model_reset();
      check_eq("midrst_ready", ready, 1);
      check_state("midrst");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_state("midrst_after");

      for (int n = 0; n < 240; n++) begin
         logic [15:0] w;
         if (n % 60 == 0) do_reset();
         if ($urandom_range(0, 29) == 0)
            w = 16'($urandom);
         else
            w = {legal_ops[$urandom_range(0, 15)], 8'($urandom)};
         send_word(w, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
